// File: rtl/axi4l_gpio_slave.sv
// axi4l_gpio_slave: AXI4-Lite subordinate exposing a five-register GPIO bank
// (OUT, DIR, IN, IRQ_EN, IRQ_STAT) with a synchronised input path and a
// registered level interrupt. One transaction is serviced at a time.
module axi4l_gpio_slave #(
  parameter int addr_width = 32,
  parameter int data_width = 32,
  parameter int gpio_width = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [addr_width-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [data_width-1:0]   WDATA,
  input  logic [data_width/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [addr_width-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [data_width-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY,
  input  logic [gpio_width-1:0]   gpio_in,
  output logic [gpio_width-1:0]   gpio_out,
  output logic [gpio_width-1:0]   gpio_oe,
  output logic                    irq
);

  localparam int StrbWidth = data_width / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WDATA = 2'd1,
    ST_WRESP = 2'd2,
    ST_RDATA = 2'd3
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  localparam logic [2:0] RegOut     = 3'd0;
  localparam logic [2:0] RegDir     = 3'd1;
  localparam logic [2:0] RegIn      = 3'd2;
  localparam logic [2:0] RegIrqEn   = 3'd3;
  localparam logic [2:0] RegIrqStat = 3'd4;

  state_e                state_q, state_d;
  logic [gpio_width-1:0] out_q, out_d;
  logic [gpio_width-1:0] dir_q, dir_d;
  logic [gpio_width-1:0] ien_q, ien_d;
  logic [gpio_width-1:0] stat_q, stat_d;
  logic [gpio_width-1:0] sync1_q, sync2_q, prev_q;
  logic [addr_width-1:0] awaddr_q, awaddr_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  bvalid_q, bvalid_d;
  logic                  rvalid_q, rvalid_d;
  logic                  irq_q;

  logic [gpio_width-1:0] wmask_s;
  logic [gpio_width-1:0] wdata_s;
  logic [gpio_width-1:0] rd_sel_s;
  logic [gpio_width-1:0] stat_clr_s;
  logic [gpio_width-1:0] stat_set_s;

  // Misaligned, above the 32-byte window, or an unmapped slot (5..7).
  function automatic logic addr_bad(input logic [addr_width-1:0] a);
    logic [addr_width-1:0] upper;
    upper = a >> 5;
    return (a[1:0] != 2'b00) || (upper != '0) || (a[4:2] > RegIrqStat);
  endfunction

  // Expand byte strobes into a per-bit mask over the implemented pins.
  function automatic logic [gpio_width-1:0] lane_mask(input logic [StrbWidth-1:0] s);
    logic [data_width-1:0] m;
    m = '0;
    for (int i = 0; i < data_width; i++) begin
      m[i] = s[i/8];
    end
    return m[gpio_width-1:0];
  endfunction

  assign wmask_s  = lane_mask(WSTRB);
  assign wdata_s  = WDATA[gpio_width-1:0];

  assign ARREADY  = (state_q == ST_IDLE) && !rst;
  assign AWREADY  = (state_q == ST_IDLE) && !ARVALID && !rst;
  assign WREADY   = (state_q == ST_WDATA) && !rst;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign RVALID   = rvalid_q;
  assign RDATA    = rdata_q;
  assign RRESP    = rresp_q;
  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = irq_q;

  // Read mux: register contents selected by the incoming read address.
  always_comb begin
    rd_sel_s = '0;
    case (ARADDR[4:2])
      RegOut:     rd_sel_s = out_q;
      RegDir:     rd_sel_s = dir_q;
      RegIn:      rd_sel_s = sync2_q;
      RegIrqEn:   rd_sel_s = ien_q;
      RegIrqStat: rd_sel_s = stat_q;
      default:    rd_sel_s = '0;
    endcase
  end

  // Next-state logic for the bus FSM, register writes and interrupt status.
  always_comb begin
    state_d    = state_q;
    out_d      = out_q;
    dir_d      = dir_q;
    ien_d      = ien_q;
    awaddr_d   = awaddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    bresp_d    = bresp_q;
    bvalid_d   = bvalid_q;
    rvalid_d   = rvalid_q;
    stat_clr_s = '0;
    stat_set_s = '0;
    stat_d     = stat_q;

    case (state_q)
      ST_IDLE: begin
        if (ARVALID) begin
          // Reads win over writes; data is captured at the AR handshake.
          if (addr_bad(ARADDR)) begin
            rdata_d = '0;
            rresp_d = RespSlvErr;
          end else begin
            rdata_d = data_width'(rd_sel_s);
            rresp_d = RespOkay;
          end
          rvalid_d = 1'b1;
          state_d  = ST_RDATA;
        end else if (AWVALID) begin
          awaddr_d = AWADDR;
          state_d  = ST_WDATA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WDATA: begin
        if (WVALID) begin
          if (addr_bad(awaddr_q) || (awaddr_q[4:2] == RegIn)) begin
            bresp_d = RespSlvErr;
          end else begin
            bresp_d = RespOkay;
            case (awaddr_q[4:2])
              RegOut:     out_d      = (out_q & ~wmask_s) | (wdata_s & wmask_s);
              RegDir:     dir_d      = (dir_q & ~wmask_s) | (wdata_s & wmask_s);
              RegIrqEn:   ien_d      = (ien_q & ~wmask_s) | (wdata_s & wmask_s);
              RegIrqStat: stat_clr_s = wdata_s & wmask_s;
              default:    stat_clr_s = '0;
            endcase
          end
          bvalid_d = 1'b1;
          state_d  = ST_WRESP;
        end else begin
          state_d = ST_WDATA;
        end
      end
      ST_WRESP: begin
        if (BREADY) begin
          bvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          bvalid_d = 1'b1;
        end
      end
      ST_RDATA: begin
        if (RREADY) begin
          rvalid_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          rvalid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Rising edge on an input pin sets status; a coincident clear loses.
    stat_set_s = sync2_q & ~prev_q & ~dir_q;
    stat_d     = (stat_q & ~stat_clr_s) | stat_set_s;
  end

  // State, register bank, synchroniser and interrupt flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      out_q    <= '0;
      dir_q    <= '0;
      ien_q    <= '0;
      stat_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      awaddr_q <= '0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
      bresp_q  <= 2'b00;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      dir_q    <= dir_d;
      ien_q    <= ien_d;
      stat_q   <= stat_d;
      sync1_q  <= gpio_in;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      awaddr_q <= awaddr_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
      rvalid_q <= rvalid_d;
      irq_q    <= |(stat_q & ien_q);
    end
  end

endmodule

// File: doc/axi4l_gpio_slave.md
Name: axi4l_gpio_slave

Overview:
- AXI4-Lite responder (subordinate) that exposes a GPIO register bank. It is the DUT-side end of the AXI4-Lite bus.
- It terminates the write and read channels driven by the bus master. It decodes a five-register map and drives GPIO pins, output enables and an interrupt line.
- It issues handshakes with the timing the bus protocol checks require: data handshake one cycle after the address handshake.

Parameters:
- addr_width, 32, AXI address width (must be ≥ 5).
- data_width, 32, AXI data width; only 32 is supported.
- gpio_width, 32, number of GPIO pins (1..data_width); unused register bits read 0.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- AWADDR  in  addr_width  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  data_width  write data.
- WSTRB  in  data_width/8  write byte strobes.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  addr_width  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  data_width  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- gpio_in  in  gpio_width  asynchronous input pins.
- gpio_out  out  gpio_width  output pin values (= OUT register).
- gpio_oe  out  gpio_width  output enables (= DIR register, 1 = drive).
- irq  out  1  level interrupt, registered.

Behaviour:
- Register map, decoded on ADDR[4:2]:
  - 0x00 OUT: read/write.
  - 0x04 DIR: read/write.
  - 0x08 IN: read-only, synchronized pins.
  - 0x0C IRQ_EN: read/write.
  - 0x10 IRQ_STAT: write-1-to-clear.
- Responses:
  - OKAY (2'b00) for valid accesses.
  - SLVERR (2'b10) for ADDR[1:0] != 0, upper address bits [addr_width-1:5] non-zero, ADDR[4:2] in 5..7, or a write to IN.
  - An error access changes no state. Read data on SLVERR is 0.
- Reset: state IDLE, all registers 0, gpio_out/gpio_oe 0, AWREADY/ARREADY 0 during rst, BVALID/RVALID 0, BRESP/RRESP/RDATA 0, irq 0, synchronizer flops 0.
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE:
  - ARREADY = 1.
  - AWREADY = !ARVALID, so a read wins when both are valid.
  - ARVALID → capture the read response into RDATA/RRESP, go to RDATA.
  - Else AWVALID → latch AWADDR, go to WDATA.
- WDATA:
  - WREADY = 1; the other readies are 0.
  - On WVALID, apply the byte lanes where the WSTRB bit is 1. WSTRB = 0 writes nothing and returns OKAY.
  - Set BRESP, BVALID = 1, go to WRESP.
- WRESP: hold BVALID/BRESP until BREADY, then go to IDLE. The next address can be accepted the cycle after the B handshake.
- RDATA: hold RVALID/RDATA/RRESP stable until RREADY, then go to IDLE.
- Latency:
  - AR handshake in cycle N → RVALID in N+1.
  - AW handshake in N → WREADY in N+1; BVALID the cycle after the W handshake.
- Read data captures register values at the AR handshake cycle. IN returns the synchronizer output at that cycle.
- gpio_in passes through a 2-flop synchronizer (sync2); IN = sync2.
- Interrupt status:
  - A prev flop on sync2 detects rising edges.
  - IRQ_STAT bit i sets when sync2[i] & !prev[i] & !DIR[i].
  - Writing 1 (with the strobed lane) clears the bit.
  - A set and a clear in the same cycle: set wins.
- irq is registered: irq <= |(IRQ_STAT & IRQ_EN), so it follows the status by one cycle.
- OUT writes take effect on gpio_out the cycle after the W handshake.
- rst asserted mid-transaction: abort, go to IDLE, drop BVALID/RVALID next edge, clear all registers. No response is issued for the aborted transfer.
- Only one outstanding transaction at a time; no pipelining.

Test Plan:
- Write 0xA5A5_00FF to 0x00 with WSTRB=4'hF, then read 0x00 → BRESP=00, RDATA=0xA5A5_00FF, gpio_out=0xA5A5_00FF, RVALID exactly 1 cycle after the AR handshake.
- Write 0xFFFF_FFFF to 0x04 with WSTRB=4'b0010, DIR previously 0 → DIR=0x0000_FF00, gpio_oe matches, BRESP=00.
- Write to 0x08, read 0x1C, read 0x02, write 0x100 → each gets SLVERR (2'b10), registers unchanged, read RDATA=0.
- DIR=0, IRQ_EN=0x1, drive gpio_in[0] 0→1 → IRQ_STAT[0]=1 after the sync delay and irq=1 one cycle later. Write 0x1 to 0x10 → IRQ_STAT=0, irq=0. A further edge in the same cycle as the clear → the bit stays 1.
- ARVALID and AWVALID high together in IDLE → read serviced first (AWREADY=0), write accepted after the R handshake. Hold RREADY=0 for 5 cycles → RDATA/RVALID stable.
- Assert rst for 1 cycle while in WRESP with BREADY=0 → BVALID=0, all registers 0, state IDLE, the next write completes normally.
